clk_reset_seq: RTL

- Parametrised successor to the single-output testbench clock/reset generator.
- Takes one free-running clock and an asynchronous active-high reset.
- Produces NUM_CH staggered, synchronously released active-high resets, a soft-reset re-sequencing path, and a programmable divided clock-enable.
- Sits at the top of project benches and in RTL subsystems that need ordered reset release (e.g. interconnect before masters).

---
 rtl/clk_reset_pkg.sv | 26 ++
 rtl/clk_reset_seq_if.sv | 33 +++
 rtl/reset_sync.sv | 27 ++
 rtl/clk_reset_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/clk_reset_pkg.sv
// rtl/clk_reset_pkg.sv - shared types, defaults and width helper for clk_reset_seq
// Purpose: sequencer state encoding, default parameter values, counter width function.
// Ports: none (package).
package clk_reset_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_HOLD,
    S_REL,
    S_DONE
  } state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYC    = 8;
  localparam int DEF_STAGGER     = 4;
  localparam int DEF_DIV_W       = 4;

  // Wide enough to hold the larger of the hold and stagger counts.
  function automatic int cnt_width(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_reset_seq_if.sv
// rtl/clk_reset_seq_if.sv - request/status bundle between a controller and clk_reset_seq
// Purpose: groups the soft-reset request, divider select and reset/enable outputs.
// Ports (signals):
//   soft_rst_req  single-cycle soft-reset request
//   ch_mask       channels taking part in a soft reset
//   div_sel       clock-enable divide ratio minus one
//   rst_out       per-channel active-high reset
//   clk_en        divided clock-enable pulse
//   seq_done      all releases complete
// Modports: master drives requests, slave is the sequencer.
interface clk_reset_seq_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4
) ();

  logic              soft_rst_req;
  logic [NUM_CH-1:0] ch_mask;
  logic [DIV_W-1:0]  div_sel;
  logic [NUM_CH-1:0] rst_out;
  logic              clk_en;
  logic              seq_done;

  modport master (
    output soft_rst_req, ch_mask, div_sel,
    input  rst_out, clk_en, seq_done
  );

  modport slave (
    input  soft_rst_req, ch_mask, div_sel,
    output rst_out, clk_en, seq_done
  );

endinterface

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - reset synchroniser, asynchronous assert, synchronous release
// Purpose: STAGES-deep flop chain; rst_sync falls on the STAGES-th edge after reset drops.
// Ports:
//   clk       free-running clock
//   reset     asynchronous active-high reset in
//   rst_sync  synchronised active-high reset out
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic rst_sync
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '1;
    end else begin
      q <= {q[STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = q[STAGES-1];

endmodule

// File: rtl/clk_reset_seq.sv
// rtl/clk_reset_seq.sv - staggered multi-channel reset sequencer with soft reset and clock-enable divider
// Purpose: releases NUM_CH resets in ascending order after a synchronised power-on release,
//          re-sequences a masked subset on soft request, and divides a clock-enable once done.
// Ports:
//   clk    free-running clock
//   reset  asynchronous active-high reset
//   bus    slave side of clk_reset_seq_if (soft_rst_req, ch_mask, div_sel in;
//          rst_out, clk_en, seq_done out)
module clk_reset_seq
  import clk_reset_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int DIV_W       = DEF_DIV_W
) (
  input logic            clk,
  input logic            reset,
  clk_reset_seq_if.slave bus
);

  localparam int CW = cnt_width(HOLD_CYC, STAGGER);
  localparam int IW = $clog2(NUM_CH) + 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     ch;      // next channel to release; NUM_CH means none left
  logic [NUM_CH-1:0] act;     // channels taking part in the current sequence
  logic [NUM_CH-1:0] rst_q;
  logic              done_q;
  logic              en_q;
  logic [DIV_W-1:0]  dcnt;
  logic [DIV_W-1:0]  dsel;    // divide ratio in force until the next wrap
  logic              rst_sync;

  reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .rst_sync (rst_sync)
  );

  // Lowest set channel at or above 'from'; NUM_CH when there is none, so
  // masked-out channels are skipped without spending stagger cycles.
  function automatic logic [IW-1:0] next_set(input logic [NUM_CH-1:0] m,
                                             input logic [IW-1:0] from);
    logic [IW-1:0] r;
    r = IW'(NUM_CH);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = IW'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_SYNC;
      cnt    <= '0;
      ch     <= '0;
      act    <= '0;
      rst_q  <= '1;
      done_q <= 1'b0;
      en_q   <= 1'b0;
      dcnt   <= '0;
      dsel   <= '0;
    end else begin
      en_q <= 1'b0;
      case (state)
        S_SYNC: begin
          // The edge that sees the synchronised release is the first hold
          // cycle, so counting starts at 1 (or releases at once for a hold of 1).
          if (!rst_sync) begin
            act <= '1;
            cnt <= '0;
            if (HOLD_CYC == 1) begin
              rst_q[0] <= 1'b0;
              ch       <= next_set('1, IW'(1));
              state    <= S_REL;
            end else begin
              ch    <= '0;
              cnt   <= CW'(1);
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (cnt == CW'(HOLD_CYC - 1)) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (i == int'(ch)) rst_q[i] <= 1'b0;
            end
            ch    <= next_set(act, ch + 1'b1);
            cnt   <= '0;
            state <= S_REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REL: begin
          if (ch == IW'(NUM_CH)) begin
            // One edge after the last release; divider starts from zero.
            done_q <= 1'b1;
            dcnt   <= '0;
            dsel   <= bus.div_sel;
            state  <= S_DONE;
          end else if (cnt == CW'(STAGGER - 1)) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (i == int'(ch)) rst_q[i] <= 1'b0;
            end
            ch  <= next_set(act, ch + 1'b1);
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.soft_rst_req && (bus.ch_mask != '0)) begin
            act    <= bus.ch_mask;
            rst_q  <= rst_q | bus.ch_mask;
            done_q <= 1'b0;
            ch     <= next_set(bus.ch_mask, '0);
            cnt    <= '0;
            state  <= S_HOLD;
          end else begin
            en_q <= (dcnt == '0);
            if (dcnt == dsel) begin
              dcnt <= '0;
              dsel <= bus.div_sel;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

  assign bus.rst_out  = rst_q;
  assign bus.clk_en   = en_q;
  assign bus.seq_done = done_q;

endmodule
